// File: rtl/mc6809_clk_seq.sv
// mc6809_clk_seq
//   Turns the fast PLL clock and the PLL lock flag into the 6809 E/Q
//   quadrature clock levels, their edge strobes, and the CPU reset.
//   The CPU stays in reset until the PLL is locked and RST_ECYCLES E cycles
//   have completed. Losing lock stops E/Q immediately and re-asserts reset.
//
// Parameters
//   DIV          CLK cycles per E/Q quarter-phase (>= 1); E period = 4*DIV
//   RST_ECYCLES  E falling edges that CPU reset is held after lock (>= 1)
//
// Ports
//   CLK        in   system clock (PLL output)
//   RESET      in   synchronous active-high reset
//   LOCKED     in   PLL lock, asynchronous to CLK
//   E, Q       out  registered 6809 clock levels (Q leads E by a quarter)
//   E_RISE     out  one-cycle pulse when E goes 0->1
//   E_FALL     out  one-cycle pulse when E goes 1->0
//   Q_RISE     out  one-cycle pulse when Q goes 0->1
//   Q_FALL     out  one-cycle pulse when Q goes 1->0
//   CPU_RESET  out  active-high reset to the CPU core
//   READY      out  high once the reset hold has finished
module mc6809_clk_seq #(
  parameter int DIV         = 4,
  parameter int RST_ECYCLES = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic LOCKED,
  output logic E,
  output logic Q,
  output logic E_RISE,
  output logic E_FALL,
  output logic Q_RISE,
  output logic Q_FALL,
  output logic CPU_RESET,
  output logic READY
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW = $clog2(RST_ECYCLES + 1);
  localparam logic [QW-1:0] QMAX  = QW'(DIV - 1);
  localparam logic [EW-1:0] EMAX  = EW'(RST_ECYCLES);
  localparam logic [EW-1:0] ELAST = EW'(RST_ECYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN_HOLD  = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [EW-1:0] ecnt, ecnt_nxt;
  logic          sync_1, lock_s;
  logic          e_nxt, q_nxt;
  logic          e_rise_nxt, e_fall_nxt, q_rise_nxt, q_fall_nxt;
  logic          cpu_reset_nxt, ready_nxt;
  logic [1:0]    phase_adv;

  // State register plus the two-flop lock synchroniser. Every output is
  // registered here so E/Q and their strobes change on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= WAIT_LOCK;
      phase     <= 2'd0;
      qcnt      <= '0;
      ecnt      <= '0;
      sync_1    <= 1'b0;
      lock_s    <= 1'b0;
      E         <= 1'b0;
      Q         <= 1'b0;
      E_RISE    <= 1'b0;
      E_FALL    <= 1'b0;
      Q_RISE    <= 1'b0;
      Q_FALL    <= 1'b0;
      CPU_RESET <= 1'b1;
      READY     <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      qcnt      <= qcnt_nxt;
      ecnt      <= ecnt_nxt;
      sync_1    <= LOCKED;
      lock_s    <= sync_1;
      E         <= e_nxt;
      Q         <= q_nxt;
      E_RISE    <= e_rise_nxt;
      E_FALL    <= e_fall_nxt;
      Q_RISE    <= q_rise_nxt;
      Q_FALL    <= q_fall_nxt;
      CPU_RESET <= cpu_reset_nxt;
      READY     <= ready_nxt;
    end
  end

  // Next-state and output decode. Lock loss wins over any phase step, so a
  // strobe that would have fired on that edge is simply not produced.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    qcnt_nxt      = qcnt;
    ecnt_nxt      = ecnt;
    e_nxt         = 1'b0;
    q_nxt         = 1'b0;
    e_rise_nxt    = 1'b0;
    e_fall_nxt    = 1'b0;
    q_rise_nxt    = 1'b0;
    q_fall_nxt    = 1'b0;
    cpu_reset_nxt = 1'b1;
    ready_nxt     = 1'b0;
    phase_adv     = phase + 2'd1;

    case (state)
      WAIT_LOCK: begin
        phase_nxt = 2'd0;
        qcnt_nxt  = '0;
        ecnt_nxt  = '0;
        if (lock_s) begin
          state_nxt = RUN_HOLD;
        end
      end

      RUN_HOLD, RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          phase_nxt = 2'd0;
          qcnt_nxt  = '0;
          ecnt_nxt  = '0;
        end else begin
          if (state == RUN) begin
            cpu_reset_nxt = 1'b0;
            ready_nxt     = 1'b1;
          end
          if (qcnt == QMAX) begin
            // Quarter boundary: E is the phase MSB, Q is the Gray-code
            // XOR of the phase bits, so Q leads E by one quarter.
            qcnt_nxt  = '0;
            phase_nxt = phase_adv;
            e_nxt     = phase_adv[1];
            q_nxt     = phase_adv[1] ^ phase_adv[0];
            case (phase_adv)
              2'd1:    q_rise_nxt = 1'b1;
              2'd2:    e_rise_nxt = 1'b1;
              2'd3:    q_fall_nxt = 1'b1;
              default: e_fall_nxt = 1'b1;
            endcase
            // Count completed E cycles during the hold; release the CPU on
            // the very edge that produces the final E falling edge.
            if (phase_adv == 2'd0 && state == RUN_HOLD) begin
              if (ecnt != EMAX) begin
                ecnt_nxt = ecnt + EW'(1);
              end
              if (ecnt == ELAST) begin
                state_nxt     = RUN;
                cpu_reset_nxt = 1'b0;
                ready_nxt     = 1'b1;
              end
            end
          end else begin
            qcnt_nxt = qcnt + QW'(1);
            e_nxt    = E;
            q_nxt    = Q;
          end
        end
      end

      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

endmodule
